// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped peripheral block: register offsets
// within the I/O window, timer control bit positions and write-enable bundle.
package mmio_pkg;

    localparam logic [31:0] OFF_TH      = 32'h0000_0000;
    localparam logic [31:0] OFF_TL      = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
    localparam logic [31:0] OFF_LED     = 32'h0000_000C;
    localparam logic [31:0] OFF_DIGI    = 32'h0000_0010;
    localparam logic [31:0] OFF_SYSTICK = 32'h0000_0014;

    // One past the last register word; anything at or above this misses.
    localparam logic [31:0] WINDOW_BYTES = 32'h0000_0018;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;
    localparam int TCON_W  = 3;

    localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

    // Per-register write strobes produced by the address decoder.
    typedef struct packed {
        logic th;
        logic tl;
        logic tcon;
        logic led;
        logic digi;
    } reg_we_t;

endpackage

// File: rtl/mmio_timer.sv
// Reloadable 32-bit up-counter with sticky overflow status and a registered
// interrupt request. Bus writes always take priority over hardware updates.
module mmio_timer
    import mmio_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we_th,
    input  logic              we_tl,
    input  logic              we_tcon,
    input  logic [31:0]       wdata,
    output logic [31:0]       th,
    output logic [31:0]       tl,
    output logic [TCON_W-1:0] tcon,
    output logic              irq
);

    logic ovf;

    // Overflow happens on the edge where an enabled counter sits at all-ones.
    assign ovf = tcon[TCON_EN] && (tl == TL_MAX);

    // Reload/count, sticky status set and one-cycle-late irq, with bus writes winning.
    always_ff @(posedge clk) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
            irq  <= 1'b0;
        end else begin
            if (we_th) begin
                th <= wdata;
            end

            // Reload reads th before this edge, so a same-edge TH write is not used.
            if (we_tl) begin
                tl <= wdata;
            end else if (tcon[TCON_EN]) begin
                tl <= ovf ? th : tl + 32'd1;
            end

            // Status is only ever cleared by software writing bit 2 low.
            if (we_tcon) begin
                tcon <= wdata[TCON_W-1:0];
            end else if (ovf && tcon[TCON_IE]) begin
                tcon[TCON_IS] <= 1'b1;
            end

            irq <= tcon[TCON_IE] & tcon[TCON_IS];
        end
    end

endmodule

// File: rtl/mmio_peripherals.sv
// I/O window on the CPU data bus: address decode, combinational read mux,
// LED / 7-segment registers, free-running tick counter and the timer.
module mmio_peripherals
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int          LED_WIDTH  = 8,
    parameter int          DIGI_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [31:0]           Address,
    input  logic [31:0]           WriteData,
    output logic [31:0]           ReadData,
    output logic                  hit,
    output logic                  irq,
    output logic [LED_WIDTH-1:0]  leds,
    output logic [DIGI_WIDTH-1:0] digi
);

    logic [31:0]       offset;
    logic [31:0]       rdata;
    logic [31:0]       th;
    logic [31:0]       tl;
    logic [31:0]       systick;
    logic [TCON_W-1:0] tcon;
    reg_we_t           we;
    logic [1:0]        unused_addr_bits;

    // Byte lane bits play no part in register selection.
    assign unused_addr_bits = Address[1:0];

    // Addresses below the base wrap to huge offsets and therefore miss.
    assign offset = {Address[31:2], 2'b00} - BASE_ADDR;
    assign hit    = (offset < WINDOW_BYTES);

    // Decode one register word into its write strobe and its zero-extended read value.
    always_comb begin
        we    = '0;
        rdata = '0;
        case (offset)
            OFF_TH: begin
                we.th = MemWrite;
                rdata = th;
            end
            OFF_TL: begin
                we.tl = MemWrite;
                rdata = tl;
            end
            OFF_TCON: begin
                we.tcon             = MemWrite;
                rdata[TCON_W-1:0]   = tcon;
            end
            OFF_LED: begin
                we.led                = MemWrite;
                rdata[LED_WIDTH-1:0]  = leds;
            end
            OFF_DIGI: begin
                we.digi               = MemWrite;
                rdata[DIGI_WIDTH-1:0] = digi;
            end
            OFF_SYSTICK: begin
                rdata = systick;
            end
            default: begin
            end
        endcase
    end

    assign ReadData = (MemRead && hit) ? rdata : 32'd0;

    mmio_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .we_th   (we.th),
        .we_tl   (we.tl),
        .we_tcon (we.tcon),
        .wdata   (WriteData),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irq     (irq)
    );

    // Output registers and the never-stopping tick counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            leds    <= '0;
            digi    <= '0;
            systick <= '0;
        end else begin
            if (we.led) begin
                leds <= WriteData[LED_WIDTH-1:0];
            end
            if (we.digi) begin
                digi <= WriteData[DIGI_WIDTH-1:0];
            end
            systick <= systick + 32'd1;
        end
    end

endmodule

// File: tb/tb_mmio_peripherals.sv
// Bench for mmio_peripherals: hand-computed vector table, a reset-while-counting
// sequence, then random bus traffic against a register-array reference model.
module tb_mmio_peripherals;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int LEDW = 8;
    localparam int DIGW = 12;

    logic            clk;
    logic            reset;
    logic            MemRead;
    logic            MemWrite;
    logic [31:0]     Address;
    logic [31:0]     WriteData;
    logic [31:0]     ReadData;
    logic            hit;
    logic            irq;
    logic [LEDW-1:0] leds;
    logic [DIGW-1:0] digi;

    mmio_peripherals #(
        .BASE_ADDR  (BASE),
        .LED_WIDTH  (LEDW),
        .DIGI_WIDTH (DIGW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .hit       (hit),
        .irq       (irq),
        .leds      (leds),
        .digi      (digi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: the six register words as software sees them, plus irq.
    logic [31:0] m_reg [6];
    logic        m_irq;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] off;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_hit;
        bit          exp_irq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rd, bit wr, logic [31:0] off, logic [31:0] wd,
                                logic [31:0] er, bit eh, bit ei);
        vec_t v;
        v.rd = rd; v.wr = wr; v.off = off; v.wd = wd;
        v.exp_rd = er; v.exp_hit = eh; v.exp_irq = ei;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic int word_idx(logic [31:0] a);
        logic [31:0] o;
        o = {a[31:2], 2'b00} - BASE;
        if (o < 32'd24) return int'(o >> 2);
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 6; k++) m_reg[k] = '0;
        m_irq = 1'b0;
    endtask

    // Apply one clock edge of the documented register behaviour to the model.
    task automatic model_edge(input bit rst, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wd);
        logic [31:0] nxt [6];
        int idx;
        bit en, ie, is_set, at_max;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 6; k++) nxt[k] = m_reg[k];
        en     = m_reg[2][0];
        ie     = m_reg[2][1];
        is_set = m_reg[2][2];
        at_max = (m_reg[1] == 32'hFFFF_FFFF);
        nxt[5] = m_reg[5] + 1;
        if (en) nxt[1] = at_max ? m_reg[0] : m_reg[1] + 1;
        if (en && at_max && ie) nxt[2] = m_reg[2] | 32'd4;
        idx = word_idx(addr);
        if (wr) begin
            case (idx)
                0: nxt[0] = wd;
                1: nxt[1] = wd;
                2: nxt[2] = wd & 32'h7;
                3: nxt[3] = wd & 32'hFF;
                4: nxt[4] = wd & 32'hFFF;
                default: ;
            endcase
        end
        m_irq = ie & is_set;
        for (int k = 0; k < 6; k++) m_reg[k] = nxt[k];
    endtask

    // One bus cycle: drive on the falling edge, check before the rising edge, advance model.
    task automatic cyc(input bit rst, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input bit use_exp, input logic [31:0] exp_rd,
                       input bit exp_hit, input bit exp_irq, input string nm);
        int idx;
        logic [31:0] m_rd;
        @(negedge clk);
        reset     = rst;
        MemRead   = rd;
        MemWrite  = wr;
        Address   = addr;
        WriteData = wd;
        #1;
        idx  = word_idx(addr);
        m_rd = (rd && idx >= 0) ? m_reg[idx] : 32'd0;
        chk({nm, ".rdata"}, ReadData, m_rd);
        chk({nm, ".hit"}, {31'd0, hit}, {31'd0, idx >= 0});
        chk({nm, ".irq"}, {31'd0, irq}, {31'd0, m_irq});
        chk({nm, ".leds"}, {24'd0, leds}, m_reg[3]);
        chk({nm, ".digi"}, {20'd0, digi}, m_reg[4]);
        if (use_exp) begin
            chk({nm, ".tbl_rdata"}, ReadData, exp_rd);
            chk({nm, ".tbl_hit"}, {31'd0, hit}, {31'd0, exp_hit});
            chk({nm, ".tbl_irq"}, {31'd0, irq}, {31'd0, exp_irq});
        end
        @(posedge clk);
        model_edge(rst, wr, addr, wd);
    endtask

    task automatic idle(input string nm);
        cyc(0, 0, 0, 32'd0, 32'd0, 0, 32'd0, 0, 0, nm);
    endtask

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
        model_reset();
        repeat (3) cyc(1, 0, 0, 32'd0, 32'd0, 0, 32'd0, 0, 0, "rst");

        // Reset values, then the overflow / irq / collision walk-through.
        tbl.push_back(mk(1, 0, 32'h14, 0, tbl.size(), 1, 0));
        tbl.push_back(mk(1, 0, 32'h00, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 32'h04, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 32'h08, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 32'h0C, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 32'h10, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 32'h14, 0, tbl.size(), 1, 0));
        tbl.push_back(mk(0, 1, 32'h00, 32'hFFFF_FFFC, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h04, 32'hFFFF_FFFC, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h08, 32'h3, 0, 1, 0));
        tbl.push_back(mk(1, 0, 32'h04, 0, 32'hFFFF_FFFC, 1, 0));
        tbl.push_back(mk(1, 0, 32'h04, 0, 32'hFFFF_FFFD, 1, 0));
        tbl.push_back(mk(1, 0, 32'h04, 0, 32'hFFFF_FFFE, 1, 0));
        tbl.push_back(mk(1, 0, 32'h04, 0, 32'hFFFF_FFFF, 1, 0));
        tbl.push_back(mk(1, 0, 32'h04, 0, 32'hFFFF_FFFC, 1, 0));
        tbl.push_back(mk(1, 0, 32'h08, 0, 32'h7, 1, 1));
        tbl.push_back(mk(1, 1, 32'h08, 32'h3, 32'h7, 1, 1));
        tbl.push_back(mk(1, 1, 32'h08, 32'h3, 32'h3, 1, 1));
        tbl.push_back(mk(1, 0, 32'h04, 0, 32'hFFFF_FFFC, 1, 0));
        tbl.push_back(mk(1, 0, 32'h08, 0, 32'h3, 1, 0));
        tbl.push_back(mk(0, 1, 32'h08, 32'h0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h04, 32'hFFFF_FFFF, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h00, 32'h1234, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h08, 32'h1, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h00, 32'h5555, 0, 1, 0));
        tbl.push_back(mk(1, 0, 32'h04, 0, 32'h1234, 1, 0));
        tbl.push_back(mk(1, 0, 32'h00, 0, 32'h5555, 1, 0));
        tbl.push_back(mk(1, 0, 32'h08, 0, 32'h1, 1, 0));
        tbl.push_back(mk(0, 1, 32'h04, 32'h10, 0, 1, 0));
        tbl.push_back(mk(1, 0, 32'h04, 0, 32'h10, 1, 0));
        tbl.push_back(mk(1, 0, 32'h04, 0, 32'h11, 1, 0));
        tbl.push_back(mk(0, 1, 32'h08, 32'h0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h0C, 32'hDEAD_BEEF, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h18, 32'hDEAD_BEEF, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0C, 0, 32'hEF, 1, 0));
        tbl.push_back(mk(1, 0, 32'h18, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h10, 32'hDEAD_BEEF, 0, 1, 0));
        tbl.push_back(mk(1, 0, 32'h10, 0, 32'hEEF, 1, 0));
        tbl.push_back(mk(1, 0, 32'h0F, 0, 32'hEF, 1, 0));
        tbl.push_back(mk(1, 0, 32'hFFFF_FFFC, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0C, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 32'h14, 32'hDEAD_BEEF, tbl.size(), 1, 0));
        tbl.push_back(mk(1, 0, 32'h14, 0, tbl.size(), 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(0, tbl[i].rd, tbl[i].wr, BASE + tbl[i].off, tbl[i].wd,
                1, tbl[i].exp_rd, tbl[i].exp_hit, tbl[i].exp_irq, $sformatf("row%0d", i));
        end

        // Reset while counting with irq asserted clears everything on that edge.
        cyc(0, 0, 1, BASE + 32'h00, 32'h0, 0, 0, 0, 0, "mr_th");
        cyc(0, 0, 1, BASE + 32'h04, 32'hFFFF_FFFE, 0, 0, 0, 0, "mr_tl");
        cyc(0, 0, 1, BASE + 32'h08, 32'h3, 0, 0, 0, 0, "mr_tcon");
        idle("mr_c1");
        idle("mr_c2");
        idle("mr_c3");
        cyc(0, 1, 0, BASE + 32'h08, 32'h0, 1, 32'h7, 1, 1, "mr_pre");
        cyc(1, 0, 0, BASE + 32'h04, 32'h0, 0, 0, 0, 0, "mr_rst");
        cyc(0, 1, 0, BASE + 32'h14, 32'h0, 1, 32'h0, 1, 0, "mr_tick");
        cyc(0, 1, 0, BASE + 32'h04, 32'h0, 1, 32'h0, 1, 0, "mr_tl0");
        cyc(0, 1, 0, BASE + 32'h08, 32'h0, 1, 32'h0, 1, 0, "mr_tcon0");

        // Random traffic, biased toward near-overflow counter values.
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [31:0] a, d;
            bit rs;
            r = $urandom_range(0, 9);
            if (r < 6)       a = BASE + r * 4 + $urandom_range(0, 3);
            else if (r == 6) a = BASE + 32'h18;
            else if (r == 7) a = BASE - 32'd4;
            else if (r == 8) a = $urandom;
            else             a = BASE + 32'h4;
            d = $urandom;
            if ((r == 0 || r == 1 || r == 9) && $urandom_range(0, 3) != 0)
                d = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            if (r == 2 && $urandom_range(0, 1) == 1) d = 32'h3;
            rs = ($urandom_range(0, 99) == 0);
            cyc(rs, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, a, d,
                0, 0, 0, 0, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmio_peripherals.md
# mmio_peripherals

Memory-mapped peripheral block on the data-memory bus of the multi-cycle CPU. It is the downstream consumer of the CPU's load/store accesses to the I/O window. It holds:
- a reloadable 32-bit timer with interrupt request,
- an LED register,
- a 7-segment digit register,
- a free-running system tick counter.

The CPU reads and writes these registers through the same MemRead/MemWrite/Address/WriteData/ReadData signals it uses for data memory. A top-level mux selects ReadData from this block whenever `hit` is high.

## Interface
Parameters:
- BASE_ADDR, 32'h4000_0000, word-aligned base of the I/O window.
- LED_WIDTH, 8, width of LED register.
- DIGI_WIDTH, 12, width of 7-segment register ({anode[3:0], seg[7:0]}).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- MemRead  input  1  CPU read strobe for the current cycle.
- MemWrite  input  1  CPU write strobe; register written at this clock edge.
- Address  input  32  byte address. Address[1:0] ignored.
- WriteData  input  32  store data.
- ReadData  output  32  combinational read data. 0 when no read hit.
- hit  output  1  combinational; Address[31:2] matches one of the six register words.
- irq  output  1  timer interrupt request, registered.
- leds  output  LED_WIDTH  LED register.
- digi  output  DIGI_WIDTH  7-segment register.

## Operation
Register map (offset from BASE_ADDR):
- 0x00 TH: reload value, R/W.
- 0x04 TL: counter, R/W.
- 0x08 TCON: R/W, bits [2:0] only; bits [31:3] read 0.
  - bit 0: enable.
  - bit 1: interrupt enable.
  - bit 2: interrupt status.
- 0x0C LED: R/W, low LED_WIDTH bits; upper bits read 0.
- 0x10 DIGI: R/W, low DIGI_WIDTH bits; upper bits read 0.
- 0x14 SYSTICK: read-only; writes ignored.

Address decode and access rules:
- Any other address: `hit`=0, ReadData=0, writes ignored.
- Reads are side-effect free.
- ReadData reflects register contents before the current edge.
- MemRead and MemWrite both high in one cycle is legal: the read returns the old value and the write lands at the edge.

Timer, evaluated every cycle with TCON[0]=1:
- If TL == 32'hFFFF_FFFF: TL <= TH; if TCON[1]=1 then TCON[2] <= 1.
- Else TL <= TL + 1 (modulo 2^32, no carry out).
- With TCON[0]=0, TL holds.
- TCON[2] is sticky. Only a bus write clears it: software writes TCON with bit 2 = 0.
- Clearing TCON[1] does not clear TCON[2].

Other state:
- irq <= TCON[1] & TCON[2], registered. It reflects TCON one cycle late.
- SYSTICK increments by 1 every cycle, wraps FFFF_FFFF -> 0, and never stops.

Collision rules, same edge:
- Bus write to TL beats the counter increment or reload; the written value is stored.
- Bus write to TCON beats the hardware set of TCON[2]. An overflow on that edge is lost if the written bit 2 = 0.
- Bus write to TH while TL reloads: the reload uses the old TH.

## Timing
- Reset: TH, TL, TCON, LED, DIGI, SYSTICK, irq all 0. ReadData=0 and hit=0 unless decoded combinationally.
- Reset mid-count clears everything on that edge, including a pending overflow.
- Write latency: value is visible on ReadData the cycle after the MemWrite edge.
- Read latency: 0 cycles, combinational.
- Overflow to irq:
  - TL = FFFF_FFFF at edge N.
  - TCON[2]=1 and TL=TH after edge N.
  - irq=1 after edge N+1.
- Timer period with TH=T: 2^32 − T cycles between overflows, where the reload edge counts as one cycle.

## Structure
Shared package (mmio_pkg):
- register offset constants: OFF_TH, OFF_TL, OFF_TCON, OFF_LED, OFF_DIGI, OFF_SYSTICK;
- TCON bit indices: TCON_EN, TCON_IE, TCON_IS.

One sub-module, mmio_timer, holds TH/TL/TCON/irq. It takes per-register write enables and WriteData, and outputs TH, TL, TCON and irq. The top level holds:
- address decode,
- the read mux,
- LED, DIGI and SYSTICK.

## Test plan
- Reset, then read all six offsets -> all return 0; irq=0.
- Write TH=FFFF_FFFC, TL=FFFF_FFFC, TCON=3 -> TL reads FFFF_FFFD, FFFF_FFFE, FFFF_FFFF on successive cycles, then FFFF_FFFC with TCON=7; irq=1 one cycle later.
- With TCON=7 and irq=1, write TCON=3 -> TCON[2]=0 next cycle, irq=0 the cycle after. Counting continues.
- TL=FFFF_FFFF, TCON=3, write TCON=3 on the overflow edge -> TCON reads 3 (write wins); TL reloads from TH.
- Write 32'hDEAD_BEEF to LED and to 0x4000_0018 -> LED reads 0000_00EF; 0x18 read returns 0 with hit=0. Write to SYSTICK is ignored: its value keeps incrementing by 1 per cycle.
- Assert reset for one cycle while TL is counting with TCON=3 -> next cycle TL=0, TCON=0, irq=0, SYSTICK=0.
